hazard_unit_mc: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage RV32 pipeline (F/D/E/M/W).

---
 rtl/hazard_unit_mc.sv | 155 +++++++++++++++
 tb/tb_hazard_unit_mc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - hazard/forwarding controller with multi-cycle execute stall FSM
//
// Purpose: drives stall/flush enables of the F/D, D/E and E/M pipeline registers
//          and operand forwarding selects for the 5-stage RV32 pipeline.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   Rs1D, Rs2D, Rs1E, Rs2E        source register addresses in D and E
//   RdE, RdM, RdW                 destination register addresses in E/M/W
//   PCSrcE                        taken branch/jump resolved in E
//   ResultSrcE0                   instruction in E is a load
//   ResultSrcM                    result select of the instruction in M
//   RegWriteE/M/W                 register write enables per stage
//   MultiCycE                     instruction in E is a multi-cycle op
//   StallF, StallD, StallE        hold PC / F-D register / D-E register
//   FlushD, FlushE, FlushM        clear F-D / D-E / E-M register
//   ForwardAE, ForwardBE          00 none, 01 ResultW, 10 ALUResultM, 11 ImmExtM
//   mc_busy                       multi-cycle FSM is in BUSY
//   stall_cycles                  saturating count of cycles with StallF=1
module hazard_unit_mc #(
    parameter int         REG_AW     = 5,
    parameter int         MC_LAT     = 4,
    parameter logic [1:0] RESULT_IMM = 2'b11,
    parameter int         PERF_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              PCSrcE,
    input  logic              ResultSrcE0,
    input  logic [1:0]        ResultSrcM,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MultiCycE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              mc_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MC_LAT - 2);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             lw_stall, mc_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [1:0]        res_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        // M has priority: it holds the younger result for the same register.
        if (src != '0 && src == rd_m && we_m)
            sel = (res_m == RESULT_IMM) ? 2'b11 : 2'b10;
        else if (src != '0 && src == rd_w && we_w)
            sel = 2'b01;
        return sel;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic: the entry cycle already stalls, so BUSY counts the
    // remaining MC_LAT-2 stall cycles and releases the op on cnt==0.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (MultiCycE) begin
                    state_nx = BUSY;
                    cnt_nx   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt != '0) cnt_nx   = cnt - CNT_W'(1);
                else           state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output logic; everything is forced quiet while reset is held.
    always_comb begin
        lw_stall = ResultSrcE0 && RegWriteE && (RdE != '0) &&
                   ((Rs1D == RdE) || (Rs2D == RdE));
        mc_stall = ((state == IDLE) && MultiCycE) ||
                   ((state == BUSY) && (cnt != '0));

        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        mc_busy   = 1'b0;

        if (rst_n) begin
            StallF    = lw_stall | mc_stall;
            StallD    = lw_stall | mc_stall;
            StallE    = mc_stall;
            FlushD    = PCSrcE;
            // E is held while the multi-cycle op occupies it, so a load-use
            // bubble must not overwrite it.
            FlushE    = PCSrcE | (lw_stall & ~mc_stall);
            FlushM    = mc_stall;
            ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, ResultSrcM, RdW, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, ResultSrcM, RdW, RegWriteW);
            mc_busy   = (state == BUSY);
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (StallF && stall_cycles != PERF_MAX)
            stall_cycles <= stall_cycles + PERF_W'(1);
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - randomized self-checking bench for hazard_unit_mc
module tb_hazard_unit_mc;

    localparam int REG_AW = 5;
    localparam int MC_LAT = 4;
    localparam int PERF_W = 4;
    localparam int PMAX   = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic              PCSrcE, ResultSrcE0, RegWriteE, RegWriteM, RegWriteW, MultiCycE;
    logic [1:0]        ResultSrcM;
    logic              StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_busy;
    logic [1:0]        ForwardAE, ForwardBE;
    logic [PERF_W-1:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: age of the multi-cycle op in E (0 = none) and stall count.
    int age  = 0;
    int perf = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(REG_AW), .MC_LAT(MC_LAT), .RESULT_IMM(2'b11), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0), .ResultSrcM(ResultSrcM),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MultiCycE(MultiCycE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mc_busy(mc_busy), .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_fwd(input int src);
        if (src != 0 && src == int'(RdM) && RegWriteM)
            return (ResultSrcM == 2'b11) ? 3 : 2;
        if (src != 0 && src == int'(RdW) && RegWriteW)
            return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        PCSrcE = 0; ResultSrcE0 = 0; ResultSrcM = 2'b00;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MultiCycE = 0;
    endtask

    // Called just after a falling edge with inputs already applied; compares all
    // outputs to the reference, advances the reference on the rising edge and
    // returns at the next falling edge.
    task automatic cycle();
        int cur, mc, lw, st;
        #2;
        if (!rst_n) begin
            age = 0;
            perf = 0;
        end
        cur = (age == 0) ? (MultiCycE ? 1 : 0) : age;
        mc  = (cur >= 1 && cur <= MC_LAT - 1) ? 1 : 0;
        lw  = (ResultSrcE0 && RegWriteE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE)) ? 1 : 0;
        st  = (lw || mc) ? 1 : 0;
        if (rst_n) begin
            check("stall_f", StallF, st);
            check("stall_d", StallD, st);
            check("stall_e", StallE, mc);
            check("flush_d", FlushD, PCSrcE);
            check("flush_e", FlushE, (PCSrcE || (lw && !mc)) ? 1 : 0);
            check("flush_m", FlushM, mc);
            check("fwd_a", ForwardAE, ref_fwd(int'(Rs1E)));
            check("fwd_b", ForwardBE, ref_fwd(int'(Rs2E)));
            check("busy", mc_busy, (age != 0) ? 1 : 0);
        end else begin
            check("rst_outs", {StallF, StallD, StallE, FlushD, FlushE, FlushM,
                               ForwardAE, ForwardBE, mc_busy}, 0);
        end
        check("perf", stall_cycles, perf);
        @(posedge clk);
        if (rst_n) begin
            if (st && perf < PMAX) perf++;
            age = (cur == 0 || cur == MC_LAT) ? 0 : cur + 1;
        end
        @(negedge clk);
    endtask

    initial begin : main
        int n_st;
        logic [3:0] busy_pat;

        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        cycle();
        rst_n = 1;
        cycle();

        // Forwarding: M beats W, immediate select
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #1 check("fwd_a_alu", ForwardAE, 2);
        cycle();
        ResultSrcM = 2'b11;
        #1 check("fwd_a_imm", ForwardAE, 3);
        cycle();

        // x0 never forwards; W forwarding when M does not match
        clear_inputs();
        Rs2E = 0; RdM = 0; RegWriteM = 1;
        #1 check("fwd_b_x0", ForwardBE, 0);
        cycle();
        Rs2E = 7; RdM = 6; RdW = 7; RegWriteW = 1;
        #1 check("fwd_b_w", ForwardBE, 1);
        cycle();

        // Load-use, and no stall for a load to x0
        clear_inputs();
        ResultSrcE0 = 1; RegWriteE = 1; RdE = 3; Rs1D = 3;
        #1 check("lw_stall", {StallF, StallD, FlushE}, 3'b111);
        cycle();
        RdE = 0; Rs1D = 0;
        #1 check("lw_x0", {StallF, StallD, FlushE}, 3'b000);
        cycle();

        // Multi-cycle op held for MC_LAT cycles: MC_LAT-1 stalls, busy on cycles 2..4
        clear_inputs();
        rst_n = 0; cycle(); rst_n = 1;
        MultiCycE = 1;
        n_st = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_st += int'(StallE && StallF && StallD && FlushM);
            busy_pat[i] = mc_busy;
            cycle();
        end
        MultiCycE = 0;
        check("mc_stall_len", n_st, MC_LAT - 1);
        check("mc_busy_pat", busy_pat, 4'b1110);
        check("mc_perf", stall_cycles, MC_LAT - 1);
        #1 check("mc_idle", mc_busy, 0);
        cycle();

        // Reset mid-op (cnt==1) clears everything at once
        MultiCycE = 1; cycle(); MultiCycE = 0;
        cycle();
        rst_n = 0;
        #1 check("rst_mid", {StallF, StallE, FlushM, mc_busy}, 0);
        cycle();
        rst_n = 1;
        #1 check("rst_after_busy", mc_busy, 0);
        check("rst_after_perf", stall_cycles, 0);
        cycle();

        // Counter saturation, then a taken branch
        ResultSrcE0 = 1; RegWriteE = 1; RdE = 9; Rs2D = 9;
        repeat (PMAX + 5) cycle();
        check("perf_sat", stall_cycles, PMAX);
        clear_inputs();
        PCSrcE = 1;
        #1 check("branch", {FlushD, FlushE, StallF}, 3'b110);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Rs1D = REG_AW'($urandom_range(0, 3)); Rs2D = REG_AW'($urandom_range(0, 3));
            Rs1E = REG_AW'($urandom_range(0, 3)); Rs2E = REG_AW'($urandom_range(0, 3));
            RdE  = REG_AW'($urandom_range(0, 3)); RdM  = REG_AW'($urandom_range(0, 3));
            RdW  = REG_AW'($urandom_range(0, 3));
            ResultSrcM  = 2'($urandom_range(0, 3));
            ResultSrcE0 = ($urandom_range(0, 2) == 0);
            RegWriteE   = $urandom_range(0, 1) != 0;
            RegWriteM   = $urandom_range(0, 1) != 0;
            RegWriteW   = $urandom_range(0, 1) != 0;
            MultiCycE   = ($urandom_range(0, 5) == 0);
            PCSrcE      = ($urandom_range(0, 7) == 0);
            rst_n       = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
